// File: rtl/hex_pkg.sv
// rtl/hex_pkg.sv - shared address map and reset constants for the seven-segment bus controller
package hex_pkg;

    localparam int BLINK_W = 24;

    localparam logic [31:0] HEX0_ADDR         = 32'h00;
    localparam logic [31:0] HEX1_ADDR         = 32'h04;
    localparam logic [31:0] HEX2_ADDR         = 32'h08;
    localparam logic [31:0] HEX3_ADDR         = 32'h0C;
    localparam logic [31:0] HEX4_ADDR         = 32'h10;
    localparam logic [31:0] HEX5_ADDR         = 32'h14;
    localparam logic [31:0] HEX6_ADDR         = 32'h18;
    localparam logic [31:0] HEX7_ADDR         = 32'h1C;
    localparam logic [31:0] BITMASK_ADDR      = 32'h20;
    localparam logic [31:0] BLINK_MASK_ADDR   = 32'h24;
    localparam logic [31:0] BLINK_PERIOD_ADDR = 32'h28;
    localparam logic [31:0] RESET_ADDR        = 32'h2C;

    localparam logic [7:0] BITMASK_RST    = 8'hFF;
    localparam logic [7:0] BLINK_MASK_RST = 8'h00;

endpackage

// File: rtl/hex_blink_gen.sv
// rtl/hex_blink_gen.sv - half-period counter and blink phase flip-flop
module hex_blink_gen
    import hex_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic [BLINK_W-1:0] period_i,
    output logic               phase_o
);

    localparam logic [BLINK_W-1:0] ONE = BLINK_W'(1);

    logic [BLINK_W-1:0] cnt_q, cnt_d;
    logic               phase_q, phase_d;

    // Count up to period-1, then wrap and toggle; a zero period or a clear parks at phase 0.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clear_i || (period_i == '0)) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == (period_i - ONE)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    // Counter and phase registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/hex_sb_ctrl.sv
// rtl/hex_sb_ctrl.sv - bus-mapped register file driving the eight-digit display stage
module hex_sb_ctrl
    import hex_pkg::*;
#(
    parameter logic [BLINK_W-1:0] BLINK_PERIOD_RST = 24'd5_000_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        write_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic [3:0]  hex0_o,
    output logic [3:0]  hex1_o,
    output logic [3:0]  hex2_o,
    output logic [3:0]  hex3_o,
    output logic [3:0]  hex4_o,
    output logic [3:0]  hex5_o,
    output logic [3:0]  hex6_o,
    output logic [3:0]  hex7_o,
    output logic [7:0]  bitmask_o
);

    logic [3:0]         hex_q [8];
    logic [3:0]         hex_d [8];
    logic [7:0]         bitmask_q, bitmask_d;
    logic [7:0]         blink_mask_q, blink_mask_d;
    logic [BLINK_W-1:0] period_q, period_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               soft_rst;
    logic               period_wr;
    logic               blink_phase;

    logic wr_en, rd_en, aligned, in_hex_range;
    assign wr_en        = req_i & write_enable_i;
    assign rd_en        = req_i & ~write_enable_i;
    assign aligned      = (addr_i[1:0] == 2'b00);
    assign in_hex_range = (addr_i[31:5] == 27'd0);

    // Register write decode, software reset and read-data mux.
    always_comb begin
        hex_d        = hex_q;
        bitmask_d    = bitmask_q;
        blink_mask_d = blink_mask_q;
        period_d     = period_q;
        rdata_d      = rdata_q;
        soft_rst     = 1'b0;
        period_wr    = 1'b0;

        if (wr_en && aligned) begin
            if (in_hex_range) begin
                hex_d[addr_i[4:2]] = write_data_i[3:0];
            end else begin
                case (addr_i)
                    BITMASK_ADDR:      bitmask_d    = write_data_i[7:0];
                    BLINK_MASK_ADDR:   blink_mask_d = write_data_i[7:0];
                    BLINK_PERIOD_ADDR: begin
                        period_d  = write_data_i[BLINK_W-1:0];
                        period_wr = 1'b1;
                    end
                    RESET_ADDR:        soft_rst = (write_data_i == 32'd1);
                    default: ;
                endcase
            end
        end

        if (rd_en) begin
            rdata_d = 32'd0;
            if (aligned) begin
                if (in_hex_range) begin
                    rdata_d = {28'd0, hex_q[addr_i[4:2]]};
                end else begin
                    case (addr_i)
                        BITMASK_ADDR:      rdata_d = {24'd0, bitmask_q};
                        BLINK_MASK_ADDR:   rdata_d = {24'd0, blink_mask_q};
                        BLINK_PERIOD_ADDR: rdata_d = {{(32-BLINK_W){1'b0}}, period_q};
                        default:           rdata_d = 32'd0;
                    endcase
                end
            end
        end

        if (soft_rst) begin
            for (int i = 0; i < 8; i++) hex_d[i] = 4'd0;
            bitmask_d    = BITMASK_RST;
            blink_mask_d = BLINK_MASK_RST;
            period_d     = BLINK_PERIOD_RST;
            rdata_d      = 32'd0;
        end
    end

    // Register file state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 8; i++) hex_q[i] <= 4'd0;
            bitmask_q    <= BITMASK_RST;
            blink_mask_q <= BLINK_MASK_RST;
            period_q     <= BLINK_PERIOD_RST;
            rdata_q      <= 32'd0;
        end else begin
            hex_q        <= hex_d;
            bitmask_q    <= bitmask_d;
            blink_mask_q <= blink_mask_d;
            period_q     <= period_d;
            rdata_q      <= rdata_d;
        end
    end

    hex_blink_gen u_blink (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (period_wr | soft_rst),
        .period_i(period_q),
        .phase_o (blink_phase)
    );

    assign read_data_o = rdata_q;
    assign hex0_o      = hex_q[0];
    assign hex1_o      = hex_q[1];
    assign hex2_o      = hex_q[2];
    assign hex3_o      = hex_q[3];
    assign hex4_o      = hex_q[4];
    assign hex5_o      = hex_q[5];
    assign hex6_o      = hex_q[6];
    assign hex7_o      = hex_q[7];
    assign bitmask_o   = blink_phase ? (bitmask_q & ~blink_mask_q) : bitmask_q;

endmodule

// File: tb/tb_hex_sb_ctrl.sv
// tb/tb_hex_sb_ctrl.sv - directed self-checking bench for hex_sb_ctrl
module tb_hex_sb_ctrl;

    localparam logic [23:0] PRST = 24'd6;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic [7:0]  bmask;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hex_sb_ctrl #(.BLINK_PERIOD_RST(PRST)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .write_enable_i(we),
        .addr_i        (addr),
        .write_data_i  (wdata),
        .read_data_o   (rdata),
        .hex0_o        (hex0),
        .hex1_o        (hex1),
        .hex2_o        (hex2),
        .hex3_o        (hex3),
        .hex4_o        (hex4),
        .hex5_o        (hex5),
        .hex6_o        (hex6),
        .hex7_o        (hex7),
        .bitmask_o     (bmask)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        req = 1'b1; we = 1'b0; addr = a;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        check("rst_hex0", {28'd0, hex0}, 32'h0);
        check("rst_hex7", {28'd0, hex7}, 32'h0);
        check("rst_bitmask", {24'd0, bmask}, 32'hFF);
        check("rst_rdata", rdata, 32'h0);
        rd(32'h20);
        check("rd_bitmask", rdata, 32'hFF);
        rd(32'h28);
        check("rd_period_rst", rdata, 32'h6);

        wr(32'h0C, 32'hFFFF_FFFA);
        check("hex3_wr", {28'd0, hex3}, 32'hA);
        rd(32'h0C);
        check("rd_hex3", rdata, 32'h0000_000A);
        rd(32'h30);
        check("rd_unmapped", rdata, 32'h0);
        rd(32'h0C);
        rd(32'h02);
        check("rd_misaligned", rdata, 32'h0);
        rd(32'h2C);
        check("rd_reset_reg", rdata, 32'h0);
        wr(32'h21, 32'h0);
        wr(32'h30, 32'h0);
        check("wr_ignored", {24'd0, bmask}, 32'hFF);

        wr(32'h20, 32'h0F);
        wr(32'h24, 32'h03);
        wr(32'h28, 32'h4);
        check("blink_e0", {24'd0, bmask}, 32'h0F);
        idle(3);
        check("blink_e3", {24'd0, bmask}, 32'h0F);
        idle(1);
        check("blink_e4", {24'd0, bmask}, 32'h0C);
        idle(3);
        check("blink_e7", {24'd0, bmask}, 32'h0C);
        idle(1);
        check("blink_e8", {24'd0, bmask}, 32'h0F);
        idle(4);
        check("blink_e12", {24'd0, bmask}, 32'h0C);
        wr(32'h28, 32'h0);
        check("period0_now", {24'd0, bmask}, 32'h0F);
        idle(10);
        check("period0_hold", {24'd0, bmask}, 32'h0F);

        wr(32'h00, 32'h5);
        wr(32'h1C, 32'h9);
        wr(32'h28, 32'h4);
        rd(32'h00);
        check("rd_hex0", rdata, 32'h5);
        wr(32'h2C, 32'h2);
        check("reset2_hex0", {28'd0, hex0}, 32'h5);
        check("reset2_rdata_hold", rdata, 32'h5);
        wr(32'h2C, 32'h1);
        check("reset1_hex0", {28'd0, hex0}, 32'h0);
        check("reset1_hex7", {28'd0, hex7}, 32'h0);
        check("reset1_hex3", {28'd0, hex3}, 32'h0);
        check("reset1_bitmask", {24'd0, bmask}, 32'hFF);
        check("reset1_rdata", rdata, 32'h0);
        rd(32'h28);
        check("reset1_period", rdata, 32'h6);
        rd(32'h24);
        check("reset1_blink_mask", rdata, 32'h0);

        wr(32'h08, 32'h7);
        wr(32'h20, 32'h0F);
        wr(32'h24, 32'h03);
        wr(32'h28, 32'h4);
        rd(32'h08);
        idle(4);
        check("pre_async_phase1", {24'd0, bmask}, 32'h0C);
        #2 rst = 1'b1;
        #1;
        check("async_hex2", {28'd0, hex2}, 32'h0);
        check("async_bitmask", {24'd0, bmask}, 32'hFF);
        check("async_rdata", rdata, 32'h0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        wr(32'h20, 32'h0F);
        wr(32'h24, 32'h03);
        check("restart_f3", {24'd0, bmask}, 32'h0F);
        idle(2);
        check("restart_f5", {24'd0, bmask}, 32'h0F);
        idle(1);
        check("restart_f6", {24'd0, bmask}, 32'h0C);
        idle(6);
        check("restart_f12", {24'd0, bmask}, 32'h0F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hex_sb_ctrl.md
Name: hex_sb_ctrl

Overview:
- Memory-mapped system-bus controller for the 8-digit seven-segment display.
- Holds eight 4-bit digit registers, an enable bitmask, a blink mask and a blink period.
- Drives hex0..hex7 and the effective bitmask directly into the downstream digit-multiplexing/decoding stage.
- Software controls the display purely by loads and stores on the peripheral bus.

Parameters:
- BLINK_PERIOD_RST, 24'd5_000_000, reset value of the BLINK_PERIOD register (blink half-period, in clock cycles).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- req_i  in  1  bus request, one transaction per cycle
- write_enable_i  in  1  1 = write, 0 = read
- addr_i  in  32  byte address within the peripheral (word aligned)
- write_data_i  in  32  write data
- read_data_o  out  32  registered read data
- hex0_o..hex7_o  out  4 each  digit values for the display stage
- bitmask_o  out  8  effective digit enable mask, after blinking is applied

Behaviour:
- Reset is asynchronous on rst_i = 1. Reset values:
  - hexN = 0
  - BITMASK = 8'hFF
  - BLINK_MASK = 0
  - BLINK_PERIOD = BLINK_PERIOD_RST
  - blink counter = 0, blink phase = 0
  - read_data_o = 0
- Address map (all RW unless noted):
  - 0x00 + 4*N: HEXN, N = 0..7; [3:0] used.
  - 0x20: BITMASK [7:0].
  - 0x24: BLINK_MASK [7:0].
  - 0x28: BLINK_PERIOD [23:0].
  - 0x2C: RESET, write-only; reads return 0.
- Write (req_i & write_enable_i):
  - The addressed register takes write_data_i truncated to its width at the next clk edge.
  - Upper bits are ignored.
  - Unmapped or misaligned addresses (addr_i[1:0] != 0, or addr_i > 0x2C): no state change.
- RESET write with write_data_i == 1: all registers, the blink counter and the blink phase return to their reset values at the next edge. Any other value is ignored.
- Read (req_i & ~write_enable_i):
  - read_data_o is updated at the next edge with the zero-extended register value, so latency is 1 cycle.
  - Unmapped addresses, misaligned addresses and RESET read as 32'h0.
  - read_data_o holds its value when there is no read.
- Outputs hexN_o and BITMASK are direct register outputs, so a write is visible one cycle after the write cycle.
- Blink generator:
  - When BLINK_PERIOD != 0, the counter increments every cycle.
  - When the counter == BLINK_PERIOD-1, it wraps to 0 and the phase toggles.
  - BLINK_PERIOD == 0: counter and phase are held at 0, so no blinking.
  - A write to BLINK_PERIOD clears the counter and phase at the same edge.
  - If BLINK_PERIOD is written with a value below the current count, the clear guarantees no overrun.
- bitmask_o is combinational from registers: phase ? (BITMASK & ~BLINK_MASK) : BITMASK.
- A reset mid-count (async or via the RESET register) restarts blinking from phase 0.
- Writes to BLINK_MASK do not disturb the counter or phase.

Decomposition:
- Package hex_pkg:
  - address localparams HEX0_ADDR..HEX7_ADDR, BITMASK_ADDR, BLINK_MASK_ADDR, BLINK_PERIOD_ADDR, RESET_ADDR
  - reset constants BITMASK_RST = 8'hFF, BLINK_MASK_RST = 8'h00
  - BLINK_W = 24
- Sub-module hex_blink_gen:
  - inputs: clk_i, rst_i, clear_i, period_i[23:0]
  - output: phase_o
  - contains the counter and the phase flip-flop.
- Top-level wiring to the display stage lives in the peripheral wrapper, not in this block.

Test Plan:
- Reset -> all hexN_o = 0, bitmask_o = 8'hFF, read_data_o = 0. Read 0x20 -> read_data_o = 32'hFF one cycle later.
- Write 0x0C <- 32'hFFFF_FFFA -> hex3_o = 4'hA next cycle. Read 0x0C -> 32'h0000_000A. Read 0x30 and read 0x02 -> 32'h0.
- Write BITMASK = 8'h0F, BLINK_MASK = 8'h03, BLINK_PERIOD = 4 -> bitmask_o alternates 8'h0F/8'h0C every 4 cycles; the first change comes 4 cycles after the period write.
- BLINK_PERIOD = 0 while in phase 1 -> bitmask_o returns to 8'h0F next cycle and stays there.
- Write values to all registers, then write RESET <- 1 -> all registers and outputs return to reset values next cycle. RESET <- 2 -> no change.
- Assert rst_i asynchronously mid-blink (between clk edges) -> outputs reset immediately, without waiting for a clock edge. After release, blinking restarts from phase 0 with period BLINK_PERIOD_RST.
